// File: rtl/mem_access_unit.sv
// RV64 load/store unit driving a 32x64 word-addressed data memory.
// Optional `MISALIGN_TRAP_EN: fault misaligned accesses instead of aligning.
module mem_access_unit #(
  parameter int BITS   = 64,
  parameter int DEPTH  = 32,
  parameter int ADDR_W = 8
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     req_valid,
  output logic                     req_ready,
  input  logic                     req_we,
  input  logic [2:0]               req_funct3,
  input  logic [ADDR_W-1:0]        req_addr,
  input  logic [BITS-1:0]          req_wdata,
  output logic                     resp_valid,
  output logic [BITS-1:0]          resp_rdata,
  output logic                     resp_err,
  output logic [$clog2(DEPTH)-1:0] mem_addr,
  output logic                     mem_we,
  output logic [BITS-1:0]          mem_din,
  input  logic [BITS-1:0]          mem_dout
);

  typedef enum logic [1:0] {IDLE, RD, WR, RESP} state_t;

  state_t              state_q, state_d;
  logic                we_q, we_d;
  logic [2:0]          f3_q, f3_d;
  logic [ADDR_W-1:0]   addr_q, addr_d;
  logic [BITS-1:0]     wdata_q, wdata_d;
  logic [BITS-1:0]     line_q, line_d;
  logic                err_q, err_d;

  logic                illegal, fault;
  logic [2:0]          off;
  logic [5:0]          sh;
  logic [7:0]          size_be, be;
  logic [BITS-1:0]     bmask, wsh, merged;
  logic [BITS-1:0]     ld_sh, ld_data;

  assign illegal = req_we ? req_funct3[2]
                          : (req_funct3 == 3'b111);

`ifdef MISALIGN_TRAP_EN
  logic misal;
  always_comb begin
    unique case (req_funct3[1:0])
      2'b00:   misal = 1'b0;
      2'b01:   misal = req_addr[0];
      2'b10:   misal = |req_addr[1:0];
      default: misal = |req_addr[2:0];
    endcase
  end
  assign fault = illegal | misal;
`else
  assign fault = illegal;
`endif

  // Offset is masked to the access size so misaligned requests align down.
  always_comb begin
    unique case (f3_q[1:0])
      2'b00:   begin size_be = 8'h01; off = addr_q[2:0];          end
      2'b01:   begin size_be = 8'h03; off = addr_q[2:0] & 3'b110; end
      2'b10:   begin size_be = 8'h0f; off = addr_q[2:0] & 3'b100; end
      default: begin size_be = 8'hff; off = 3'b000;               end
    endcase
  end

  assign sh = {off, 3'b000};
  assign be = size_be << off;

  always_comb begin
    bmask = '0;
    for (int i = 0; i < 8; i++) begin
      bmask[8*i +: 8] = {8{be[i]}};
    end
  end

  assign wsh    = wdata_q << sh;
  assign merged = (line_q & ~bmask) | (wsh & bmask);
  assign ld_sh  = line_q >> sh;

  always_comb begin
    unique case (f3_q)
      3'b000:  ld_data = {{(BITS-8){ld_sh[7]}},   ld_sh[7:0]};
      3'b001:  ld_data = {{(BITS-16){ld_sh[15]}}, ld_sh[15:0]};
      3'b010:  ld_data = {{(BITS-32){ld_sh[31]}}, ld_sh[31:0]};
      3'b011:  ld_data = ld_sh;
      3'b100:  ld_data = {{(BITS-8){1'b0}},  ld_sh[7:0]};
      3'b101:  ld_data = {{(BITS-16){1'b0}}, ld_sh[15:0]};
      3'b110:  ld_data = {{(BITS-32){1'b0}}, ld_sh[31:0]};
      default: ld_data = '0;
    endcase
  end

  always_comb begin
    state_d = state_q;
    we_d    = we_q;
    f3_d    = f3_q;
    addr_d  = addr_q;
    wdata_d = wdata_q;
    line_d  = line_q;
    err_d   = err_q;
    unique case (state_q)
      IDLE: begin
        err_d = 1'b0;
        if (req_valid) begin
          we_d    = req_we;
          f3_d    = req_funct3;
          addr_d  = req_addr;
          wdata_d = req_wdata;
          err_d   = fault;
          state_d = fault ? RESP : RD;
        end
      end
      RD: begin
        line_d  = mem_dout;
        state_d = we_q ? WR : RESP;
      end
      WR:      state_d = RESP;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      we_q    <= 1'b0;
      f3_q    <= 3'b000;
      addr_q  <= '0;
      wdata_q <= '0;
      line_q  <= '0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      we_q    <= we_d;
      f3_q    <= f3_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      line_q  <= line_d;
      err_q   <= err_d;
    end
  end

  assign req_ready  = (state_q == IDLE);
  assign resp_valid = (state_q == RESP);
  assign resp_err   = resp_valid & err_q;
  assign resp_rdata = (resp_valid & ~we_q & ~err_q)
                      ? ld_data : '0;
  assign mem_addr   = addr_q[ADDR_W-1:3];
  assign mem_we     = (state_q == WR) && !rst;
  assign mem_din    = (state_q == WR) ? merged : '0;

endmodule
